// File: rtl/asic_cfg_scheduler_if.sv
// asic_cfg_scheduler_if
//   Request/ack handshake and serial register-port signals of the configuration
//   scheduler.
//   master : requester side (drives requests and data, observes acks and serial pins)
//   slave  : scheduler side (samples requests and data, drives acks and serial pins)
interface asic_cfg_scheduler_if #(
    parameter int SIZESRDYN  = 16,
    parameter int SIZESRSTAT = 88
);
    logic                  dyn_req;
    logic [SIZESRDYN-1:0]  dyn_data;
    logic                  dyn_ack;
    logic                  stat_req;
    logic [SIZESRSTAT-1:0] stat_data;
    logic                  stat_ack;
    logic                  SEL;
    logic                  MOSI;
    logic                  SCLK;
    logic                  frame_active;
    logic                  busy;

    modport master (
        output dyn_req, dyn_data, stat_req, stat_data,
        input  dyn_ack, stat_ack, SEL, MOSI, SCLK, frame_active, busy
    );

    modport slave (
        input  dyn_req, dyn_data, stat_req, stat_data,
        output dyn_ack, stat_ack, SEL, MOSI, SCLK, frame_active, busy
    );
endinterface

// File: rtl/asic_cfg_scheduler.sv
// asic_cfg_scheduler
//   Arbitrates between a dynamic (SIZESRDYN-bit) and a static (SIZESRSTAT-bit)
//   register load request and shifts the granted word out MSB-first on MOSI with
//   a generated SCLK. Everything runs on CLK; SCLK is a registered output toggled
//   on clock-enable ticks, so there is no derived clock inside the block.
//   Ports:
//     CLK    system clock, posedge
//     RST_N  asynchronous active-low reset
//     bus    asic_cfg_scheduler_if.slave: dyn/stat req, data, ack;
//            SEL, MOSI, SCLK, frame_active, busy
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for a request; divider held at 0
//   ST_SHIFT | frame in progress; SCLK toggles every tick
//   ST_GAP   | enforced idle after a frame, GAP_TICKS ticks long
module asic_cfg_scheduler #(
    parameter int SIZESRDYN  = 16,
    parameter int SIZESRSTAT = 88,
    parameter int CLK_DIV    = 8,
    parameter int GAP_TICKS  = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    asic_cfg_scheduler_if.slave   bus
);
    localparam int BCW = $clog2(SIZESRSTAT);
    localparam int DCW = $clog2(CLK_DIV);
    localparam int GCW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int PAD = SIZESRSTAT - SIZESRDYN;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [DCW-1:0] DIV_LAST  = DCW'(CLK_DIV - 1);
    localparam logic [BCW-1:0] DYN_LAST  = BCW'(SIZESRDYN - 1);
    localparam logic [BCW-1:0] STAT_LAST = BCW'(SIZESRSTAT - 1);
    localparam logic [GCW-1:0] GAP_LAST  = GCW'(GAP_TICKS - 1);

    logic [1:0]            state_q, state_d;
    logic [DCW-1:0]        div_cnt_q, div_cnt_d;
    logic [SIZESRSTAT-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [GCW-1:0]        gap_cnt_q, gap_cnt_d;
    logic                  last_dyn_q, last_dyn_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  sel_q, sel_d;
    logic                  fa_q, fa_d;
    logic                  busy_q, busy_d;
    logic                  dyn_ack_q, dyn_ack_d;
    logic                  stat_ack_q, stat_ack_d;
    logic                  tick;
    logic                  grant_dyn, grant_stat;

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        last_dyn_d = last_dyn_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        sel_d      = sel_q;
        fa_d       = fa_q;
        dyn_ack_d  = 1'b0;
        stat_ack_d = 1'b0;
        grant_dyn  = 1'b0;
        grant_stat = 1'b0;

        tick = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick ? '0 : div_cnt_q + DCW'(1);

        case (state_q)
            ST_IDLE: begin
                div_cnt_d = '0;
                // On contention the requester that did not win last time goes first.
                grant_dyn  = bus.dyn_req  && (!bus.stat_req || !last_dyn_q);
                grant_stat = bus.stat_req && (!bus.dyn_req  ||  last_dyn_q);
                if (grant_dyn) begin
                    dyn_ack_d  = 1'b1;
                    shreg_d    = {bus.dyn_data, {PAD{1'b0}}};
                    bit_cnt_d  = DYN_LAST;
                    mosi_d     = bus.dyn_data[SIZESRDYN-1];
                    sel_d      = 1'b1;
                    last_dyn_d = 1'b1;
                end else if (grant_stat) begin
                    stat_ack_d = 1'b1;
                    shreg_d    = bus.stat_data;
                    bit_cnt_d  = STAT_LAST;
                    mosi_d     = bus.stat_data[SIZESRSTAT-1];
                    sel_d      = 1'b0;
                    last_dyn_d = 1'b0;
                end
                if (grant_dyn || grant_stat) begin
                    fa_d    = 1'b1;
                    sclk_d  = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    // Data only moves on the falling SCLK tick, so MOSI is centred
                    // on the rising edge the target samples.
                    if (sclk_q) begin
                        if (bit_cnt_q != '0) begin
                            shreg_d   = {shreg_q[SIZESRSTAT-2:0], 1'b0};
                            mosi_d    = shreg_q[SIZESRSTAT-2];
                            bit_cnt_d = bit_cnt_q - BCW'(1);
                        end else begin
                            mosi_d    = 1'b0;
                            fa_d      = 1'b0;
                            gap_cnt_d = '0;
                            state_d   = ST_GAP;
                        end
                    end
                end
            end
            ST_GAP: begin
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (tick) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        sel_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GCW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                sel_d   = 1'b0;
                fa_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            last_dyn_q <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            sel_q      <= 1'b0;
            fa_q       <= 1'b0;
            busy_q     <= 1'b0;
            dyn_ack_q  <= 1'b0;
            stat_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            last_dyn_q <= last_dyn_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            sel_q      <= sel_d;
            fa_q       <= fa_d;
            busy_q     <= busy_d;
            dyn_ack_q  <= dyn_ack_d;
            stat_ack_q <= stat_ack_d;
        end
    end

    assign bus.dyn_ack      = dyn_ack_q;
    assign bus.stat_ack     = stat_ack_q;
    assign bus.SEL          = sel_q;
    assign bus.MOSI         = mosi_q;
    assign bus.SCLK         = sclk_q;
    assign bus.frame_active = fa_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_asic_cfg_scheduler.sv
// Testbench for asic_cfg_scheduler. The expected serial waveform is computed
// per CLK from the frame start time: bit index = t / (2*D), SCLK = (t / D) mod 2.
module tb_asic_cfg_scheduler;
    localparam int D  = 2;
    localparam int G  = 3;
    localparam int ND = 16;
    localparam int NS = 88;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   t_fall = 0;

    asic_cfg_scheduler_if #(.SIZESRDYN(ND), .SIZESRSTAT(NS)) bus ();

    asic_cfg_scheduler #(
        .SIZESRDYN(ND), .SIZESRSTAT(NS), .CLK_DIV(D), .GAP_TICKS(G)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .bus(bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_dyn_ack"},  96'(bus.dyn_ack), 96'(0));
        chk({pfx, "_stat_ack"}, 96'(bus.stat_ack), 96'(0));
        chk({pfx, "_sel"},      96'(bus.SEL), 96'(0));
        chk({pfx, "_mosi"},     96'(bus.MOSI), 96'(0));
        chk({pfx, "_sclk"},     96'(bus.SCLK), 96'(0));
        chk({pfx, "_fa"},       96'(bus.frame_active), 96'(0));
        chk({pfx, "_busy"},     96'(bus.busy), 96'(0));
    endtask

    function automatic logic [NS-1:0] dyn_word(input logic [ND-1:0] d);
        return {d, {(NS-ND){1'b0}}};
    endfunction

    // Waits for the grant, then follows the frame and the gap cycle by cycle.
    // word is left-aligned in NS bits; exp_lat > 0 checks grant time after the
    // previous frame_active fall.
    task automatic check_frame(input bit exp_dyn, input logic [NS-1:0] word, input int n,
                               input bit drop, input int exp_lat);
        int w, t0, t, idx, nrise, bad_mosi, bad_sclk, bad_sel, bad_busy, extra, bad_gap;
        logic prev, em;
        logic [NS-1:0] cap;
        w = 0;
        while (!(bus.dyn_ack || bus.stat_ack) && w < 40) begin
            @(negedge CLK);
            w++;
        end
        chk("ack_seen", 96'(bus.dyn_ack | bus.stat_ack), 96'(1));
        if (!(bus.dyn_ack || bus.stat_ack)) return;
        chk("ack_kind", 96'({bus.dyn_ack, bus.stat_ack}), exp_dyn ? 96'(2) : 96'(1));
        t0 = cyc;
        if (exp_lat > 0) chk("grant_after_gap", 96'(t0 - t_fall), 96'(exp_lat));
        chk("sel_at_grant", 96'(bus.SEL), 96'(exp_dyn));
        chk("fa_at_grant", 96'(bus.frame_active), 96'(1));
        if (drop) begin
            if (exp_dyn) begin
                bus.dyn_req = 1'b0;
                bus.dyn_data = ~bus.dyn_data;
            end else begin
                bus.stat_req = 1'b0;
                bus.stat_data = ~bus.stat_data;
            end
        end
        nrise = 0; bad_mosi = 0; bad_sclk = 0; bad_sel = 0; bad_busy = 0; extra = 0;
        cap = '0;
        prev = bus.SCLK;
        t = 0;
        while (bus.frame_active && t <= 2 * n * D + 8) begin
            idx = t / (2 * D);
            em = (idx < n) ? word[NS-1-idx] : 1'b0;
            if (bus.MOSI !== em) bad_mosi++;
            if (bus.SCLK !== 1'((t / D) % 2)) bad_sclk++;
            if (bus.SEL !== exp_dyn) bad_sel++;
            if (bus.busy !== 1'b1) bad_busy++;
            if (t > 0 && (bus.dyn_ack || bus.stat_ack)) extra++;
            if (bus.SCLK && !prev) begin
                cap = {cap[NS-2:0], bus.MOSI};
                nrise++;
            end
            prev = bus.SCLK;
            @(negedge CLK);
            t = cyc - t0;
        end
        t_fall = cyc;
        chk("frame_len", 96'(t), 96'(2 * n * D));
        chk("rise_count", 96'(nrise), 96'(n));
        chk("captured_word", 96'(cap << (NS - n)), 96'(word));
        chk("mosi_wave_errs", 96'(bad_mosi), 96'(0));
        chk("sclk_wave_errs", 96'(bad_sclk), 96'(0));
        chk("sel_errs", 96'(bad_sel), 96'(0));
        chk("busy_errs", 96'(bad_busy), 96'(0));
        chk("extra_acks", 96'(extra), 96'(0));
        chk("mosi_after", 96'(bus.MOSI), 96'(0));
        chk("sclk_after", 96'(bus.SCLK), 96'(0));
        bad_gap = 0;
        w = 0;
        while (bus.busy && w < G * D + 8) begin
            if (bus.SEL !== exp_dyn || bus.MOSI !== 1'b0 || bus.SCLK !== 1'b0) bad_gap++;
            @(negedge CLK);
            w++;
        end
        chk("busy_tail", 96'(cyc - t_fall), 96'(G * D));
        chk("gap_errs", 96'(bad_gap), 96'(0));
        chk("sel_idle", 96'(bus.SEL), 96'(0));
    endtask

    initial begin
        logic [95:0] r96;
        logic [ND-1:0] d16;
        logic [NS-1:0] s88;
        int seen, w, t0;
        bit typ;

        bus.dyn_req = 1'b0;
        bus.stat_req = 1'b0;
        bus.dyn_data = '0;
        bus.stat_data = '0;

        // Reset values
        repeat (3) @(negedge CLK);
        chk_reset_outputs("in_reset");
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        chk_reset_outputs("after_reset");

        // Dynamic frame with a fixed pattern, then a back-to-back dynamic request
        bus.dyn_data = 16'hABC6;
        bus.dyn_req = 1'b1;
        check_frame(1'b1, dyn_word(16'hABC6), ND, 1'b1, 0);
        d16 = 16'($urandom());
        bus.dyn_data = d16;
        bus.dyn_req = 1'b1;
        check_frame(1'b1, dyn_word(d16), ND, 1'b1, G * D + 1);

        // Static frame with a fixed pattern (last bit 1)
        s88 = 88'h123456789ABCDEF1234567;
        bus.stat_data = s88;
        bus.stat_req = 1'b1;
        check_frame(1'b0, s88, NS, 1'b1, 0);

        // Random single requests after random idle times
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge CLK);
            typ = 1'($urandom());
            r96 = {$urandom(), $urandom(), $urandom()};
            if (typ) begin
                d16 = r96[ND-1:0];
                bus.dyn_data = d16;
                bus.dyn_req = 1'b1;
                check_frame(1'b1, dyn_word(d16), ND, 1'b1, 0);
            end else begin
                s88 = r96[NS-1:0];
                bus.stat_data = s88;
                bus.stat_req = 1'b1;
                check_frame(1'b0, s88, NS, 1'b1, 0);
            end
        end

        // Dynamic request raised mid static frame waits for the gap
        r96 = {$urandom(), $urandom(), $urandom()};
        s88 = r96[NS-1:0];
        d16 = 16'($urandom());
        bus.stat_data = s88;
        bus.stat_req = 1'b1;
        fork
            check_frame(1'b0, s88, NS, 1'b1, 0);
            begin
                repeat ($urandom_range(10, 300)) @(negedge CLK);
                bus.dyn_data = d16;
                bus.dyn_req = 1'b1;
            end
        join
        check_frame(1'b1, dyn_word(d16), ND, 1'b1, G * D + 1);

        // One-cycle dynamic pulse mid frame is withdrawn silently
        r96 = {$urandom(), $urandom(), $urandom()};
        s88 = r96[NS-1:0];
        bus.stat_data = s88;
        bus.stat_req = 1'b1;
        fork
            check_frame(1'b0, s88, NS, 1'b1, 0);
            begin
                repeat ($urandom_range(10, 300)) @(negedge CLK);
                bus.dyn_req = 1'b1;
                @(negedge CLK);
                bus.dyn_req = 1'b0;
            end
        join
        seen = 0;
        repeat (30) begin
            if (bus.dyn_ack || bus.stat_ack) seen++;
            @(negedge CLK);
        end
        chk("no_ack_for_pulse", 96'(seen), 96'(0));

        // Simultaneous requests after reset: static, dynamic, static, dynamic
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        r96 = {$urandom(), $urandom(), $urandom()};
        s88 = r96[NS-1:0];
        d16 = 16'($urandom());
        bus.stat_data = s88;
        bus.dyn_data = d16;
        bus.stat_req = 1'b1;
        bus.dyn_req = 1'b1;
        check_frame(1'b0, s88, NS, 1'b0, 0);
        check_frame(1'b1, dyn_word(d16), ND, 1'b0, G * D + 1);
        check_frame(1'b0, s88, NS, 1'b0, G * D + 1);
        check_frame(1'b1, dyn_word(d16), ND, 1'b0, G * D + 1);
        bus.stat_req = 1'b0;
        bus.dyn_req = 1'b0;
        repeat (5) @(negedge CLK);

        // Reset in the middle of dynamic bit 7
        d16 = 16'($urandom());
        bus.dyn_data = d16;
        bus.dyn_req = 1'b1;
        w = 0;
        while (!bus.dyn_ack && w < 40) begin
            @(negedge CLK);
            w++;
        end
        chk("rst_case_ack", 96'(bus.dyn_ack), 96'(1));
        t0 = cyc;
        bus.dyn_req = 1'b0;
        repeat ((2 * 7 + 1) * D) @(negedge CLK);
        chk("rst_case_sclk_high", 96'(bus.SCLK), 96'(1));
        chk("rst_case_fa_high", 96'(bus.frame_active), 96'(1));
        #1 RST_N = 1'b0;
        #1 chk_reset_outputs("mid_frame_rst");
        r96 = {$urandom(), $urandom(), $urandom()};
        s88 = r96[NS-1:0];
        d16 = 16'($urandom());
        bus.stat_data = s88;
        bus.dyn_data = d16;
        bus.stat_req = 1'b1;
        bus.dyn_req = 1'b1;
        @(negedge CLK);
        chk_reset_outputs("held_rst");
        RST_N = 1'b1;
        check_frame(1'b0, s88, NS, 1'b1, 0);
        check_frame(1'b1, dyn_word(d16), ND, 1'b1, G * D + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
